// File: rtl/mcl86_biu_pkg.sv
// Shared definitions for the EU->BIU command responder: command field
// positions, op codes, segment selects and the responder state encoding.
package mcl86_biu_pkg;

    localparam int CMD_REQ    = 9;
    localparam int CMD_WORD   = 8;
    localparam int CMD_SEG_HI = 4;
    localparam int CMD_SEG_LO = 3;
    localparam int CMD_OP_HI  = 2;
    localparam int CMD_OP_LO  = 0;

    localparam logic [2:0] BIU_OP_MRD   = 3'd0;
    localparam logic [2:0] BIU_OP_MWR   = 3'd1;
    localparam logic [2:0] BIU_OP_IORD  = 3'd2;
    localparam logic [2:0] BIU_OP_IOWR  = 3'd3;
    localparam logic [2:0] BIU_OP_INTA  = 3'd4;
    localparam logic [2:0] BIU_OP_FLUSH = 3'd5;
    localparam logic [2:0] BIU_OP_NOP   = 3'd6;

    typedef enum logic [1:0] {
        SEG_ES = 2'b00,
        SEG_SS = 2'b01,
        SEG_CS = 2'b10,
        SEG_DS = 2'b11
    } seg_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_CYC1 = 3'd2,
        ST_CYC2 = 3'd3,
        ST_DONE = 3'd4
    } biu_state_e;

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == BIU_OP_MRD) || (op == BIU_OP_IORD) || (op == BIU_OP_INTA);
    endfunction

    function automatic logic op_is_write(input logic [2:0] op);
        return (op == BIU_OP_MWR) || (op == BIU_OP_IOWR);
    endfunction

    function automatic logic op_is_io(input logic [2:0] op);
        return (op == BIU_OP_IORD) || (op == BIU_OP_IOWR);
    endfunction

endpackage

// File: rtl/mcl86_biu_addr_gen.sv
// Segment register mux and physical / I/O address formation for the
// responder's byte cycles; purely combinational.
module mcl86_biu_addr_gen
    import mcl86_biu_pkg::*;
#(
    parameter int SEG_SHIFT = 4,
    parameter int IO_ADDR_W = 16
) (
    input  logic [1:0]  seg_sel,
    input  logic [15:0] seg_es,
    input  logic [15:0] seg_ss,
    input  logic [15:0] seg_cs,
    input  logic [15:0] seg_ds,
    output logic [15:0] seg_sel_val,
    input  logic [15:0] seg_base,
    input  logic [15:0] offset,
    input  logic [2:0]  op,
    input  logic        second,
    output logic [19:0] phys_addr
);

    logic [15:0]          off_eff;
    logic [19:0]          seg_ext;
    logic [IO_ADDR_W-1:0] io_port;

    always_comb begin
        case (seg_sel)
            SEG_ES:  seg_sel_val = seg_es;
            SEG_SS:  seg_sel_val = seg_ss;
            SEG_CS:  seg_sel_val = seg_cs;
            default: seg_sel_val = seg_ds;
        endcase
    end

    // The second byte wraps inside the 64K segment, not into the next one.
    assign off_eff = second ? (offset + 16'd1) : offset;
    assign seg_ext = 20'(seg_base) << SEG_SHIFT;
    assign io_port = off_eff[IO_ADDR_W-1:0];

    always_comb begin
        if (op == BIU_OP_INTA) begin
            phys_addr = 20'h0_0000;
        end else if (op_is_io(op)) begin
            phys_addr = 20'(io_port);
        end else begin
            phys_addr = seg_ext + {4'h0, off_eff};
        end
    end

endmodule

// File: rtl/mcl86_biu_cmd_responder.sv
// BIU side of the EU command handshake: arbitrates the 8-bit bus against the
// prefetcher, runs one or two byte cycles and reports completion as a level.
//
// state   | meaning
// IDLE    | waiting for a new EU request (BIU_DONE low)
// ARB     | command latched, waiting for the prefetcher to release the bus
// CYC1    | first byte cycle on the bus, BUS_REQ held until BUS_ACK
// CYC2    | second byte cycle (offset+1, high data byte)
// DONE    | BIU_DONE high until the EU drops its request
module mcl86_biu_cmd_responder
    import mcl86_biu_pkg::*;
#(
    parameter int SEG_SHIFT = 4,
    parameter int IO_ADDR_W = 16
) (
    input  logic        CORE_CLK_INT,
    input  logic        RESET_INT,
    input  logic [15:0] EU_BIU_COMMAND,
    input  logic [15:0] EU_BIU_DATAOUT,
    input  logic [15:0] EU_REGISTER_R3,
    input  logic [15:0] BIU_REGISTER_ES,
    input  logic [15:0] BIU_REGISTER_SS,
    input  logic [15:0] BIU_REGISTER_CS,
    input  logic [15:0] BIU_REGISTER_DS,
    output logic        BIU_DONE,
    output logic [15:0] BIU_RETURN_DATA,
    input  logic        PFQ_BUS_BUSY,
    output logic        PFQ_FLUSH,
    output logic [15:0] PFQ_NEW_IP,
    output logic        BUS_REQ,
    output logic [19:0] BUS_ADDR,
    output logic        BUS_WR,
    output logic        BUS_IO,
    output logic        BUS_INTA,
    output logic [7:0]  BUS_DOUT,
    input  logic [7:0]  BUS_DIN,
    input  logic        BUS_ACK
);

    biu_state_e  state_q, state_d;
    logic        second_q, second_d;
    logic        word_q, word_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] seg_q, seg_d;
    logic [15:0] offset_q, offset_d;
    logic [15:0] data_q, data_d;
    logic        done_q, done_d;
    logic [15:0] ret_q, ret_d;
    logic        flush_q, flush_d;
    logic [15:0] new_ip_q, new_ip_d;
    logic        bus_req_q, bus_req_d;
    logic [19:0] bus_addr_q, bus_addr_d;
    logic        bus_wr_q, bus_wr_d;
    logic        bus_io_q, bus_io_d;
    logic        bus_inta_q, bus_inta_d;
    logic [7:0]  bus_dout_q, bus_dout_d;

    logic        req_in;
    logic        word_in;
    logic [1:0]  seg_sel_in;
    logic [2:0]  op_in;
    logic        accept;
    logic        two_bytes;
    logic [15:0] seg_sel_val;
    logic [19:0] phys_addr;
    logic        unused_cmd;

    assign req_in     = EU_BIU_COMMAND[CMD_REQ];
    assign word_in    = EU_BIU_COMMAND[CMD_WORD];
    assign seg_sel_in = EU_BIU_COMMAND[CMD_SEG_HI:CMD_SEG_LO];
    assign op_in      = EU_BIU_COMMAND[CMD_OP_HI:CMD_OP_LO];
    assign unused_cmd = ^{EU_BIU_COMMAND[15:10], EU_BIU_COMMAND[7:5]};

    // Only IDLE with DONE low accepts, so the EU always sees DONE fall.
    assign accept    = (state_q == ST_IDLE) && req_in && !done_q;
    assign two_bytes = word_q && (op_q != BIU_OP_INTA);

    mcl86_biu_addr_gen #(
        .SEG_SHIFT (SEG_SHIFT),
        .IO_ADDR_W (IO_ADDR_W)
    ) u_addr_gen (
        .seg_sel     (seg_sel_in),
        .seg_es      (BIU_REGISTER_ES),
        .seg_ss      (BIU_REGISTER_SS),
        .seg_cs      (BIU_REGISTER_CS),
        .seg_ds      (BIU_REGISTER_DS),
        .seg_sel_val (seg_sel_val),
        .seg_base    (seg_q),
        .offset      (offset_q),
        .op          (op_q),
        .second      (second_q),
        .phys_addr   (phys_addr)
    );

    always_ff @(posedge CORE_CLK_INT) begin
        if (RESET_INT) begin
            state_q    <= ST_IDLE;
            second_q   <= 1'b0;
            word_q     <= 1'b0;
            op_q       <= 3'd0;
            seg_q      <= 16'h0000;
            offset_q   <= 16'h0000;
            data_q     <= 16'h0000;
            done_q     <= 1'b0;
            ret_q      <= 16'h0000;
            flush_q    <= 1'b0;
            new_ip_q   <= 16'h0000;
            bus_req_q  <= 1'b0;
            bus_addr_q <= 20'h0_0000;
            bus_wr_q   <= 1'b0;
            bus_io_q   <= 1'b0;
            bus_inta_q <= 1'b0;
            bus_dout_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            second_q   <= second_d;
            word_q     <= word_d;
            op_q       <= op_d;
            seg_q      <= seg_d;
            offset_q   <= offset_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ret_q      <= ret_d;
            flush_q    <= flush_d;
            new_ip_q   <= new_ip_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
            bus_wr_q   <= bus_wr_d;
            bus_io_q   <= bus_io_d;
            bus_inta_q <= bus_inta_d;
            bus_dout_q <= bus_dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_in >= BIU_OP_FLUSH) state_d = ST_DONE;
                    else                       state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!PFQ_BUS_BUSY) state_d = second_q ? ST_CYC2 : ST_CYC1;
            end
            ST_CYC1: begin
                if (BUS_ACK) state_d = two_bytes ? ST_ARB : ST_DONE;
            end
            ST_CYC2: begin
                if (BUS_ACK) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!req_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        second_d   = second_q;
        word_d     = word_q;
        op_d       = op_q;
        seg_d      = seg_q;
        offset_d   = offset_q;
        data_d     = data_q;
        ret_d      = ret_q;
        flush_d    = 1'b0;
        new_ip_d   = new_ip_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        bus_wr_d   = bus_wr_q;
        bus_io_d   = bus_io_q;
        bus_inta_d = bus_inta_q;
        bus_dout_d = bus_dout_q;
        done_d     = (state_d == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    second_d = 1'b0;
                    word_d   = word_in;
                    op_d     = op_in;
                    seg_d    = seg_sel_val;
                    offset_d = EU_REGISTER_R3;
                    data_d   = EU_BIU_DATAOUT;
                    if (op_in == BIU_OP_FLUSH) begin
                        flush_d  = 1'b1;
                        new_ip_d = EU_REGISTER_R3;
                    end
                end
            end
            ST_ARB: begin
                if (!PFQ_BUS_BUSY) begin
                    bus_req_d  = 1'b1;
                    bus_addr_d = phys_addr;
                    bus_wr_d   = op_is_write(op_q);
                    bus_io_d   = op_is_io(op_q);
                    bus_inta_d = (op_q == BIU_OP_INTA);
                    if (op_is_write(op_q)) bus_dout_d = second_q ? data_q[15:8] : data_q[7:0];
                    else                   bus_dout_d = 8'h00;
                end
            end
            ST_CYC1: begin
                if (BUS_ACK) begin
                    bus_req_d = 1'b0;
                    second_d  = two_bytes;
                    if (op_is_read(op_q)) begin
                        ret_d[7:0] = BUS_DIN;
                        if (!two_bytes) ret_d[15:8] = 8'h00;
                    end
                end
            end
            ST_CYC2: begin
                if (BUS_ACK) begin
                    bus_req_d = 1'b0;
                    if (op_is_read(op_q)) ret_d[15:8] = BUS_DIN;
                end
            end
            default: ;
        endcase
    end

    assign BIU_DONE        = done_q;
    assign BIU_RETURN_DATA = ret_q;
    assign PFQ_FLUSH       = flush_q;
    assign PFQ_NEW_IP      = new_ip_q;
    assign BUS_REQ         = bus_req_q;
    assign BUS_ADDR        = bus_addr_q;
    assign BUS_WR          = bus_wr_q;
    assign BUS_IO          = bus_io_q;
    assign BUS_INTA        = bus_inta_q;
    assign BUS_DOUT        = bus_dout_q;

endmodule

// File: tb/tb_mcl86_biu_cmd_responder.sv
// Directed bench for mcl86_biu_cmd_responder: a table of complete EU
// transactions plus hand sequences for arbitration, reset and handshake.
module tb_mcl86_biu_cmd_responder;

    logic        CORE_CLK_INT = 1'b0;
    logic        RESET_INT;
    logic [15:0] EU_BIU_COMMAND, EU_BIU_DATAOUT, EU_REGISTER_R3;
    logic [15:0] BIU_REGISTER_ES, BIU_REGISTER_SS, BIU_REGISTER_CS, BIU_REGISTER_DS;
    logic        BIU_DONE;
    logic [15:0] BIU_RETURN_DATA;
    logic        PFQ_BUS_BUSY;
    logic        PFQ_FLUSH;
    logic [15:0] PFQ_NEW_IP;
    logic        BUS_REQ;
    logic [19:0] BUS_ADDR;
    logic        BUS_WR, BUS_IO, BUS_INTA;
    logic [7:0]  BUS_DOUT;
    logic [7:0]  BUS_DIN;
    logic        BUS_ACK;

    mcl86_biu_cmd_responder dut (
        .CORE_CLK_INT    (CORE_CLK_INT),
        .RESET_INT       (RESET_INT),
        .EU_BIU_COMMAND  (EU_BIU_COMMAND),
        .EU_BIU_DATAOUT  (EU_BIU_DATAOUT),
        .EU_REGISTER_R3  (EU_REGISTER_R3),
        .BIU_REGISTER_ES (BIU_REGISTER_ES),
        .BIU_REGISTER_SS (BIU_REGISTER_SS),
        .BIU_REGISTER_CS (BIU_REGISTER_CS),
        .BIU_REGISTER_DS (BIU_REGISTER_DS),
        .BIU_DONE        (BIU_DONE),
        .BIU_RETURN_DATA (BIU_RETURN_DATA),
        .PFQ_BUS_BUSY    (PFQ_BUS_BUSY),
        .PFQ_FLUSH       (PFQ_FLUSH),
        .PFQ_NEW_IP      (PFQ_NEW_IP),
        .BUS_REQ         (BUS_REQ),
        .BUS_ADDR        (BUS_ADDR),
        .BUS_WR          (BUS_WR),
        .BUS_IO          (BUS_IO),
        .BUS_INTA        (BUS_INTA),
        .BUS_DOUT        (BUS_DOUT),
        .BUS_DIN         (BUS_DIN),
        .BUS_ACK         (BUS_ACK)
    );

    always #5 CORE_CLK_INT = ~CORE_CLK_INT;

    typedef struct {
        logic [15:0] cmd, r3, dout, es, ss, cs, ds;
        logic [7:0]  din0, din1;
        int          ncyc;
        logic [19:0] addr0, addr1;
        logic [7:0]  bd0, bd1;
        logic [2:0]  attr;   // {wr, io, inta}
        logic [15:0] ret;
        int          flush;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    int   flush_cnt = 0;
    int   req_rises = 0;
    logic req_prev = 1'b0;

    always @(negedge CORE_CLK_INT) begin
        if (PFQ_FLUSH) flush_cnt++;
        if (BUS_REQ && !req_prev) req_rises++;
        req_prev = BUS_REQ;
    end

    function automatic vec_t mk(
        input logic [15:0] cmd, r3, dout, es, ss, cs, ds,
        input logic [7:0] din0, din1, input int ncyc,
        input logic [19:0] addr0, addr1, input logic [7:0] bd0, bd1,
        input logic [2:0] attr, input logic [15:0] ret, input int flush);
        vec_t v;
        v.cmd = cmd; v.r3 = r3; v.dout = dout;
        v.es = es; v.ss = ss; v.cs = cs; v.ds = ds;
        v.din0 = din0; v.din1 = din1; v.ncyc = ncyc;
        v.addr0 = addr0; v.addr1 = addr1; v.bd0 = bd0; v.bd1 = bd1;
        v.attr = attr; v.ret = ret; v.flush = flush;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CORE_CLK_INT);
        #1;
    endtask

    task automatic wait_req(output int t);
        t = 0;
        do begin
            tick();
            t++;
        end while (!BUS_REQ && t < 20);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   t, f0, r0;
        logic [19:0] a;
        v = vecs[i];
        BIU_REGISTER_ES = v.es; BIU_REGISTER_SS = v.ss;
        BIU_REGISTER_CS = v.cs; BIU_REGISTER_DS = v.ds;
        EU_REGISTER_R3 = v.r3; EU_BIU_DATAOUT = v.dout;
        f0 = flush_cnt; r0 = req_rises;
        EU_BIU_COMMAND = v.cmd;
        for (int c = 0; c < v.ncyc; c++) begin
            wait_req(t);
            check($sformatf("v%0d_c%0d_latency", i, c), t, (c == 0) ? 2 : 1);
            a = (c == 0) ? v.addr0 : v.addr1;
            check($sformatf("v%0d_c%0d_addr", i, c), BUS_ADDR, a);
            check($sformatf("v%0d_c%0d_attr", i, c), {BUS_WR, BUS_IO, BUS_INTA}, v.attr);
            if (v.attr[2]) check($sformatf("v%0d_c%0d_dout", i, c), BUS_DOUT, (c == 0) ? v.bd0 : v.bd1);
            // Live inputs change mid-operation; the latched copies must win.
            EU_REGISTER_R3 = v.r3 ^ 16'h5A5A; EU_BIU_DATAOUT = ~v.dout;
            BIU_REGISTER_ES = ~v.es; BIU_REGISTER_SS = ~v.ss;
            BIU_REGISTER_CS = ~v.cs; BIU_REGISTER_DS = ~v.ds;
            tick(); tick();
            check($sformatf("v%0d_c%0d_hold", i, c), {BUS_REQ, BUS_ADDR}, {1'b1, a});
            BUS_ACK = 1'b1; BUS_DIN = (c == 0) ? v.din0 : v.din1;
            tick();
            BUS_ACK = 1'b0; BUS_DIN = 8'h00;
            check($sformatf("v%0d_c%0d_req_drop", i, c), BUS_REQ, 1'b0);
        end
        t = 0;
        while (!BIU_DONE && t < 20) begin tick(); t++; end
        check($sformatf("v%0d_done", i), BIU_DONE, 1'b1);
        check($sformatf("v%0d_ret", i), BIU_RETURN_DATA, v.ret);
        tick(); tick(); tick();
        check($sformatf("v%0d_done_held", i), BIU_DONE, 1'b1);
        check($sformatf("v%0d_req_count", i), req_rises - r0, v.ncyc);
        check($sformatf("v%0d_flush_count", i), flush_cnt - f0, v.flush);
        if (v.flush != 0) check($sformatf("v%0d_new_ip", i), PFQ_NEW_IP, v.r3);
        EU_BIU_COMMAND = 16'h0000;
        tick();
        check($sformatf("v%0d_done_clear", i), BIU_DONE, 1'b0);
    endtask

    initial begin
        int t;
        int seen;

        vecs[0] = mk(16'h0218, 16'h0234, 16'h0000, 16'h2000, 16'h3000, 16'h4000, 16'h1000,
                     8'h5A, 8'h00, 1, 20'h10234, 20'h00000, 8'h00, 8'h00, 3'b000, 16'h005A, 0);
        vecs[1] = mk(16'h0309, 16'hFFFF, 16'hBEEF, 16'h0001, 16'hFFFF, 16'h0002, 16'h0003,
                     8'h00, 8'h00, 2, 20'h0FFEF, 20'hFFFF0, 8'hEF, 8'hBE, 3'b100, 16'h005A, 0);
        vecs[2] = mk(16'h0302, 16'hFFFF, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                     8'h11, 8'h22, 2, 20'h0FFFF, 20'h00000, 8'h00, 8'h00, 3'b010, 16'h2211, 0);
        vecs[3] = mk(16'h0304, 16'h0100, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                     8'h08, 8'h00, 1, 20'h00000, 20'h00000, 8'h00, 8'h00, 3'b001, 16'h0008, 0);
        vecs[4] = mk(16'h0205, 16'h1234, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                     8'h00, 8'h00, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 3'b000, 16'h0008, 1);
        vecs[5] = mk(16'h0206, 16'h5678, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                     8'h00, 8'h00, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 3'b000, 16'h0008, 0);
        vecs[6] = mk(16'h0201, 16'h0010, 16'hA55A, 16'h1234, 16'h5000, 16'h6000, 16'h7000,
                     8'h00, 8'h00, 1, 20'h12350, 20'h00000, 8'h5A, 8'h00, 3'b100, 16'h0008, 0);
        vecs[7] = mk(16'h0310, 16'h1FFF, 16'h0000, 16'h0100, 16'h0200, 16'hF000, 16'h0300,
                     8'h34, 8'h12, 2, 20'hF1FFF, 20'hF2000, 8'h00, 8'h00, 3'b000, 16'h1234, 0);
        vecs[8] = mk(16'h0203, 16'h0080, 16'h00C3, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                     8'h00, 8'h00, 1, 20'h00080, 20'h00000, 8'hC3, 8'h00, 3'b110, 16'h1234, 0);
        vecs[9] = mk(16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h2000, 16'h3000,
                     8'hFF, 8'h00, 1, 20'h00000, 20'h00000, 8'h00, 8'h00, 3'b000, 16'h00FF, 0);

        RESET_INT = 1'b1; EU_BIU_COMMAND = 16'h0000; EU_BIU_DATAOUT = 16'h0000;
        EU_REGISTER_R3 = 16'h0000; BIU_REGISTER_ES = 16'h0000; BIU_REGISTER_SS = 16'h0000;
        BIU_REGISTER_CS = 16'h0000; BIU_REGISTER_DS = 16'h0000;
        PFQ_BUS_BUSY = 1'b0; BUS_DIN = 8'h00; BUS_ACK = 1'b0;
        tick(); tick(); tick();
        check("reset_ctrl", {BIU_DONE, PFQ_FLUSH, BUS_REQ, BUS_WR, BUS_IO, BUS_INTA}, 6'b0);
        check("reset_data", {BIU_RETURN_DATA, PFQ_NEW_IP}, 32'h0);
        check("reset_bus", {BUS_ADDR, BUS_DOUT}, 28'h0);
        RESET_INT = 1'b0;
        tick();

        // Stray ACK while idle must not touch the return data.
        BUS_ACK = 1'b1; BUS_DIN = 8'h77;
        tick();
        BUS_ACK = 1'b0; BUS_DIN = 8'h00;
        tick();
        check("idle_ack_ignored", {BUS_REQ, BIU_DONE, BIU_RETURN_DATA}, 18'h0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Prefetcher holds the bus; a later busy during the cycle is ignored.
        PFQ_BUS_BUSY = 1'b1; EU_REGISTER_R3 = 16'h03F8; EU_BIU_COMMAND = 16'h0202;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (BUS_REQ) seen++;
        end
        check("arb_wait_no_req", seen, 0);
        PFQ_BUS_BUSY = 1'b0;
        tick();
        check("arb_grant_req", BUS_REQ, 1'b1);
        check("arb_io_addr", {BUS_IO, BUS_WR, BUS_ADDR}, {1'b1, 1'b0, 20'h003F8});
        PFQ_BUS_BUSY = 1'b1; BUS_ACK = 1'b1; BUS_DIN = 8'hC4;
        tick();
        BUS_ACK = 1'b0; BUS_DIN = 8'h00;
        check("arb_done", BIU_DONE, 1'b1);
        check("arb_ret", BIU_RETURN_DATA, 16'h00C4);
        PFQ_BUS_BUSY = 1'b0; EU_BIU_COMMAND = 16'h0000;
        tick();
        check("arb_done_clear", BIU_DONE, 1'b0);

        // Reset during the second byte of a word read.
        BIU_REGISTER_DS = 16'h0500; EU_REGISTER_R3 = 16'h0010; EU_BIU_COMMAND = 16'h0318;
        wait_req(t);
        check("rst_c1_addr", BUS_ADDR, 20'h05010);
        BUS_ACK = 1'b1; BUS_DIN = 8'h99;
        tick();
        BUS_ACK = 1'b0; BUS_DIN = 8'h00;
        wait_req(t);
        check("rst_c2_addr", {BUS_REQ, BUS_ADDR}, {1'b1, 20'h05011});
        RESET_INT = 1'b1;
        tick();
        check("rst_mid_ctrl", {BUS_REQ, BIU_DONE, PFQ_FLUSH}, 3'b000);
        check("rst_mid_ret", BIU_RETURN_DATA, 16'h0000);
        RESET_INT = 1'b0; EU_BIU_COMMAND = 16'h0000;
        tick();
        check("rst_idle", {BUS_REQ, BIU_DONE}, 2'b00);
        run_vec(0);

        // Req held across DONE, then re-raised with a new command one cycle after the drop.
        BIU_REGISTER_ES = 16'h0000; EU_REGISTER_R3 = 16'h0005; EU_BIU_DATAOUT = 16'h0066;
        EU_BIU_COMMAND = 16'h0200;
        wait_req(t);
        BUS_ACK = 1'b1; BUS_DIN = 8'h42;
        tick();
        BUS_ACK = 1'b0; BUS_DIN = 8'h00;
        tick(); tick();
        check("hs_done_held", {BIU_DONE, BUS_REQ}, 2'b10);
        EU_BIU_COMMAND = 16'h0000;
        tick();
        check("hs_done_low", BIU_DONE, 1'b0);
        EU_BIU_COMMAND = 16'h0201;
        tick();
        check("hs_accept_arb", {BIU_DONE, BUS_REQ}, 2'b00);
        tick();
        check("hs_new_req", {BUS_REQ, BUS_WR, BUS_ADDR, BUS_DOUT}, {1'b1, 1'b1, 20'h00005, 8'h66});
        BUS_ACK = 1'b1;
        tick();
        BUS_ACK = 1'b0;
        check("hs_new_done", {BIU_DONE, BIU_RETURN_DATA}, {1'b1, 16'h0042});
        EU_BIU_COMMAND = 16'h0000;
        tick();
        check("hs_new_clear", BIU_DONE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
